boule_rouge_spawner: RTL
========================

BOULE_ROUGE_SPAWNER -- requirements
Module: boule_rouge_spawner

Interface
REQ-001 Parameter DF_DELAY, default 32'd50000000: spawn delay in clk cycles, used when e_spawn_delay is 0.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; SHALL be non-zero.
REQ-003 clk  in  1  single system clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 e_start_qb, e_pause_qb, e_resume_qb  in  1 each  game restart / pause / resume controls.
REQ-006 e_spawn_delay  in  32  cycles between end of one ball and next spawn; 0 selects DF_DELAY.
REQ-007 e_pattern  in  7  bit6 = override enable; bits[5:0] = forced move pattern.
REQ-008 e_XY0_top  in  21  screen {x[10:0], y[9:0]} of top cube.
REQ-009 done_move_br  in  1  level from ball layer, high after each completed hop.
REQ-010 boule_rouge_end  in  1  ball layer finished (fade-out done or killed).
REQ-011 e_enable_br  out  1  spawn pulse to ball layer.
REQ-012 e_move_br  out  6  hop pattern; bit k = direction of hop k (0 = right edge, 1 = left edge).
REQ-013 e_XY0_br  out  21  spawn position; equals e_XY0_top latched at spawn.
REQ-014 br_cube  out  32  one-hot cube position, bit (n-1) = cube n (1..28); 0 when no ball.
REQ-015 br_active  out  1  ball in play.
REQ-016 spawn_cnt  out  8  balls spawned since restart, saturating at 255.

Function
REQ-017 Game states RESUME and PAUSE: RESUME -> PAUSE on e_pause_qb; PAUSE -> RESUME on e_resume_qb; in PAUSE, e_start_qb performs restart (REQ-027) and enters RESUME; e_resume_qb has priority over e_start_qb.
REQ-018 In PAUSE, all counters, LFSR and spawn FSM SHALL hold; outputs hold except e_enable_br, which is 0.
REQ-019 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts once per RESUME cycle.
REQ-020 Spawn FSM states WAIT, SPAWN, TRACK, DRAIN; WAIT entered after reset and restart.
REQ-021 WAIT: counter increments each RESUME cycle; when count == delay-1 (delay = e_spawn_delay or DF_DELAY), clear count, go SPAWN.
REQ-022 SPAWN (one cycle): e_enable_br = 1 for exactly this cycle; latch e_move_br = e_pattern[6] ? e_pattern[5:0] : lfsr[5:0]; latch e_XY0_br = e_XY0_top; br_cube = cube 1; br_active = 1; hop index = 0; spawn_cnt += 1 (saturating); go TRACK.
REQ-023 TRACK: rising edge of done_move_br (registered previous value, cleared in SPAWN) with hop index k < 6: current cube n on row r moves to n + r if e_move_br[k] = 0, else n + r + 1; row and k increment.
REQ-024 Rising edges beyond the sixth hop SHALL be ignored; cube index never exceeds 28.
REQ-025 boule_rouge_end high in TRACK (any hop count) -> DRAIN; same cycle as a done_move_br rising edge: end wins, no position update.
REQ-026 DRAIN: br_cube = 0, br_active = 0; when boule_rouge_end is low, go WAIT with count = 0.
REQ-027 Restart: spawn FSM to WAIT, count = 0, br_cube = 0, br_active = 0, spawn_cnt = 0, e_enable_br = 0; LFSR not reseeded.
REQ-028 Delay change during WAIT takes effect immediately; if count already >= new delay-1, spawn next cycle.

Reset
REQ-029 On reset low, regardless of clock: game state RESUME, spawn FSM WAIT, count 0, LFSR = LFSR_SEED, e_enable_br 0, e_move_br 0, e_XY0_br 0, br_cube 0, br_active 0, spawn_cnt 0, edge register 0.
REQ-030 Reset assertion mid-TRACK SHALL abandon the ball with no further e_enable_br until a full delay elapses after release.

Verification
REQ-031 e_spawn_delay = 10, reset released -> e_enable_br one-cycle pulse on the 10th RESUME cycle, spawn_cnt = 1, br_cube = 32'h1.
REQ-032 e_pattern = 7'h40, six done_move_br pulses -> br_cube sequence 1,2,4,7,11,16,22 (32'h00200000 final).
REQ-033 e_pattern = 7'h7F, six pulses -> cubes 1,3,6,10,15,21,28 (32'h08000000 final); seventh pulse -> no change.
REQ-034 Pause for 100 cycles during WAIT with delay 50 -> spawn occurs 100 cycles later than unpaused; LFSR value at spawn matches model advanced only in RESUME.
REQ-035 boule_rouge_end after 2 hops, coincident with a done_move_br rising edge -> br_cube = 0 next cycle, DRAIN, then WAIT, next spawn after full delay.
REQ-036 Pause then e_start_qb with spawn_cnt = 3 -> spawn_cnt = 0, br_active = 0, WAIT, count = 0.

Source files
------------

// File: rtl/boule_rouge_spawner.sv
// Red-ball spawner: paces ball spawns, chooses each ball's hop pattern and
// tracks its cube on the pyramid from the ball layer's hop/end handshakes.
module boule_rouge_spawner #(
    parameter logic [31:0] DF_DELAY  = 32'd50000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start_qb,
    input  logic        e_pause_qb,
    input  logic        e_resume_qb,
    input  logic [31:0] e_spawn_delay,
    input  logic [6:0]  e_pattern,
    input  logic [20:0] e_XY0_top,
    input  logic        done_move_br,
    input  logic        boule_rouge_end,
    output logic        e_enable_br,
    output logic [5:0]  e_move_br,
    output logic [20:0] e_XY0_br,
    output logic [31:0] br_cube,
    output logic        br_active,
    output logic [7:0]  spawn_cnt
);

    typedef enum logic {
        G_RESUME = 1'b0,
        G_PAUSE  = 1'b1
    } game_e;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SPAWN = 2'd1,
        S_TRACK = 2'd2,
        S_DRAIN = 2'd3
    } spawn_e;

    game_e       game_q, game_d;
    spawn_e      st_q, st_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        enable_q, enable_d;
    logic [5:0]  move_q, move_d;
    logic [20:0] xy_q, xy_d;
    logic [31:0] cube_q, cube_d;
    logic [4:0]  cube_n_q, cube_n_d;
    logic [2:0]  hop_q, hop_d;
    logic        active_q, active_d;
    logic [7:0]  spawn_cnt_q, spawn_cnt_d;
    logic        done_prev_q, done_prev_d;

    logic [31:0] delay_s;
    logic        rise_s;
    logic [4:0]  row_s;
    logic [7:0]  move_pad_s;
    logic [4:0]  next_n_s;

    // Fibonacci LFSR, taps 16,14,13,11 (bit numbering from 1)
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [31:0] cube_onehot(input logic [4:0] n);
        cube_onehot = 32'd1 << (n - 5'd1);
    endfunction

    // Effective delay, hop edge detect and landing cube of the next hop
    always_comb begin
        delay_s    = (e_spawn_delay == 32'd0) ? DF_DELAY : e_spawn_delay;
        rise_s     = done_move_br & ~done_prev_q;
        row_s      = {2'b00, hop_q} + 5'd1;
        move_pad_s = {2'b00, move_q};
        next_n_s   = cube_n_q + row_s + {4'b0000, move_pad_s[hop_q]};
    end

    // Game pause/resume control and spawn FSM next state
    always_comb begin
        game_d      = game_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        move_d      = move_q;
        xy_d        = xy_q;
        cube_d      = cube_q;
        cube_n_d    = cube_n_q;
        hop_d       = hop_q;
        active_d    = active_q;
        spawn_cnt_d = spawn_cnt_q;
        done_prev_d = done_prev_q;
        enable_d    = 1'b0;

        case (game_q)
            G_PAUSE: begin
                if (e_resume_qb) begin
                    game_d = G_RESUME;
                end else if (e_start_qb) begin
                    game_d      = G_RESUME;
                    st_d        = S_WAIT;
                    cnt_d       = 32'd0;
                    cube_d      = 32'd0;
                    active_d    = 1'b0;
                    spawn_cnt_d = 8'd0;
                    hop_d       = 3'd0;
                end else begin
                    game_d = G_PAUSE;
                end
            end
            G_RESUME: begin
                if (e_pause_qb) begin
                    game_d = G_PAUSE;
                end else begin
                    game_d = G_RESUME;
                end
                lfsr_d = lfsr_step(lfsr_q);
                case (st_q)
                    S_WAIT: begin
                        // >= so that shrinking the delay mid-wait spawns at once
                        if (cnt_q >= delay_s - 32'd1) begin
                            cnt_d       = 32'd0;
                            st_d        = S_SPAWN;
                            move_d      = e_pattern[6] ? e_pattern[5:0] : lfsr_q[5:0];
                            xy_d        = e_XY0_top;
                            cube_n_d    = 5'd1;
                            cube_d      = 32'd1;
                            active_d    = 1'b1;
                            hop_d       = 3'd0;
                            done_prev_d = 1'b0;
                            spawn_cnt_d = (spawn_cnt_q == 8'hFF) ? 8'hFF : spawn_cnt_q + 8'd1;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    S_SPAWN: begin
                        done_prev_d = 1'b0;
                        st_d        = S_TRACK;
                    end
                    S_TRACK: begin
                        done_prev_d = done_move_br;
                        if (boule_rouge_end) begin
                            st_d     = S_DRAIN;
                            cube_d   = 32'd0;
                            active_d = 1'b0;
                        end else if (rise_s && (hop_q < 3'd6)) begin
                            cube_n_d = next_n_s;
                            cube_d   = cube_onehot(next_n_s);
                            hop_d    = hop_q + 3'd1;
                        end else begin
                            st_d = S_TRACK;
                        end
                    end
                    S_DRAIN: begin
                        if (!boule_rouge_end) begin
                            st_d  = S_WAIT;
                            cnt_d = 32'd0;
                        end else begin
                            st_d = S_DRAIN;
                        end
                    end
                    default: st_d = S_WAIT;
                endcase
            end
            default: game_d = G_RESUME;
        endcase

        // A spawn caught by a pause is announced on the first resumed cycle
        enable_d = (st_d == S_SPAWN) && (game_d == G_RESUME);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            game_q      <= G_RESUME;
            st_q        <= S_WAIT;
            cnt_q       <= 32'd0;
            lfsr_q      <= LFSR_SEED;
            enable_q    <= 1'b0;
            move_q      <= 6'd0;
            xy_q        <= 21'd0;
            cube_q      <= 32'd0;
            cube_n_q    <= 5'd0;
            hop_q       <= 3'd0;
            active_q    <= 1'b0;
            spawn_cnt_q <= 8'd0;
            done_prev_q <= 1'b0;
        end else begin
            game_q      <= game_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            enable_q    <= enable_d;
            move_q      <= move_d;
            xy_q        <= xy_d;
            cube_q      <= cube_d;
            cube_n_q    <= cube_n_d;
            hop_q       <= hop_d;
            active_q    <= active_d;
            spawn_cnt_q <= spawn_cnt_d;
            done_prev_q <= done_prev_d;
        end
    end

    assign e_enable_br = enable_q;
    assign e_move_br   = move_q;
    assign e_XY0_br    = xy_q;
    assign br_cube     = cube_q;
    assign br_active   = active_q;
    assign spawn_cnt   = spawn_cnt_q;

endmodule
